// File: rtl/cb_dff_pipe.sv
// cb_dff_pipe: clock-enabled register pipeline with per-stage valid and valid/ready backpressure
module cb_dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v_q, v_d, rdy, up_v;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d, up_d;
  logic [OW-1:0] occ_q, occ_d;
  logic go, xin, xout;
  for (genvar g = 0; g < DEPTH; g++) begin : g_up
    if (g == 0) begin : g_head
      assign up_v[g] = in_valid;
      assign up_d[g] = in_data;
    end else begin : g_body
      assign up_v[g] = v_q[g-1];
      assign up_d[g] = d_q[g-1];
    end
  end
  assign go        = en & ~clr;
  assign in_ready  = go & rdy[0] & ~rst;
  assign out_valid = en & v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;
  assign xin       = in_valid & in_ready;
  assign xout      = out_valid & out_ready;
  // A stage is ready when empty or when everything downstream can move, so bubbles collapse
  always_comb begin
    rdy[DEPTH-1] = ~v_q[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) rdy[i] = ~v_q[i] | rdy[i+1];
    v_d = v_q;
    d_d = d_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (go && rdy[i]) begin
        v_d[i] = up_v[i];
        if (up_v[i]) d_d[i] = up_d[i];
      end
    end
    if (clr) begin
      v_d = '0;
      d_d = {DEPTH{RESET_VAL}};
    end
    occ_d = clr ? '0 : occ_q + OW'(xin & ~xout) - OW'(xout & ~xin);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= {DEPTH{RESET_VAL}};
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end
  a_occ : assert property (@(posedge clk) disable iff (rst) occ_q == OW'($countones(v_q)));
endmodule

// File: tb/tb_cb_dff_pipe.sv
// tb_cb_dff_pipe: scoreboard bench for cb_dff_pipe (WIDTH=8, DEPTH=3)
module tb_cb_dff_pipe;
  logic clk = 0, rst = 1, en = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] in_data = 0, out_data;
  logic [1:0] occupancy;
  logic [7:0] q[$];
  int total = 0, bad = 0;
  cb_dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Observe transfers at negedge, advance one clock, then check occupancy against the queue depth
  task automatic step();
    logic do_clr;
    @(negedge clk);
    do_clr = clr;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("underflow", 1, 0);
      else chk("sb_data", out_data, q.pop_front());
    end
    if (in_valid && in_ready) q.push_back(in_data);
    @(posedge clk);
    if (do_clr) q.delete();
    #1;
    if (!rst) chk("sb_occ", occupancy, q.size());
  endtask
  task automatic send(input logic [7:0] w);
    in_valid = 1;
    in_data  = w;
    step();
  endtask
  task automatic drain();
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && occupancy != 0; i++) step();
    step();
    chk("drain_occ", occupancy, 0);
    chk("drain_sb", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 8'h00);
    @(posedge clk); #1;
    rst = 0; en = 1; out_ready = 1;
    // streaming with latency check
    send(8'h11);
    chk("lat1_v", out_valid, 0);
    send(8'h22);
    chk("lat2_v", out_valid, 0);
    send(8'h33);
    chk("lat3_v", out_valid, 1);
    chk("lat3_d", out_data, 8'h11);
    chk("full_occ", occupancy, 3);
    send(8'h44);
    chk("steady_occ", occupancy, 3);
    chk("steady_d", out_data, 8'h22);
    send(8'h55);
    chk("steady_d2", out_data, 8'h33);
    drain();
    // backpressure fill and pass-through accept
    out_ready = 0;
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
    chk("bp_acc", q.size(), 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_occ", occupancy, 3);
    chk("bp_data", out_data, 8'hA0);
    chk("bp_valid", out_valid, 1);
    out_ready = 1; in_valid = 1; in_data = 8'hA5; #1;
    chk("pass_in_ready", in_ready, 1);
    step();
    drain();
    // bubble collapse
    out_ready = 0;
    send(8'h5A);
    in_valid = 0;
    step(); step();
    in_valid = 1; in_data = 8'h6B; #1;
    chk("bub_in_ready", in_ready, 1);
    step();
    chk("bub_occ", occupancy, 2);
    chk("bub_data", out_data, 8'h5A);
    drain();
    // enable freeze
    out_ready = 0;
    send(8'h71); send(8'h72);
    en = 0; in_valid = 1; in_data = 8'h73; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("en0_in_ready", in_ready, 0);
      chk("en0_out_valid", out_valid, 0);
      step();
      chk("en0_occ", occupancy, 2);
    end
    en = 1;
    drain();
    // clear while full and disabled, then normal latency
    out_ready = 0;
    send(8'h81); send(8'h82); send(8'h83);
    chk("clr_pre_occ", occupancy, 3);
    in_valid = 0; en = 0; clr = 1;
    step();
    clr = 0; en = 1;
    chk("clr_occ", occupancy, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_out_data", out_data, 8'h00);
    out_ready = 1;
    send(8'h90);
    in_valid = 0;
    chk("clr_lat1", out_valid, 0);
    step();
    chk("clr_lat2", out_valid, 0);
    step();
    chk("clr_lat3_v", out_valid, 1);
    chk("clr_lat3_d", out_data, 8'h90);
    drain();
    // clear with enable high blocks input
    clr = 1; in_valid = 1; #1;
    chk("clr_in_ready", in_ready, 0);
    step();
    clr = 0; in_valid = 0;
    // async reset mid-cycle
    out_ready = 0;
    send(8'hC1); send(8'hC2);
    in_valid = 0;
    chk("pre_rst_occ", occupancy, 2);
    #2 rst = 1; #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_in_ready", in_ready, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 0;
    // random soak
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      en        = $urandom_range(0, 7) != 0;
      step();
    end
    en = 1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
